dmx_channel_store: RTL and testbench

Channel value store that sits directly upstream of the DMX512 serial writer and answers its per-frame data requests. The motion-tracking processor writes target levels per channel; the store returns the current level for any requested address one cycle after the request pulse. An optional slew engine fades each current level toward its target once per DMX packet, so tracked fixtures move smoothly instead of stepping.

---
 rtl/dmx_pkg.sv | 17 +
 rtl/dmx_slew_step.sv | 23 ++
 rtl/dmx_channel_store.sv | 128 ++++++++++++
 tb/tb_dmx_channel_store.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmx_pkg.sv
// Shared widths, slew FSM encoding and read response type for the DMX channel store.
package dmx_pkg;
  localparam int DMX_ADDR_W       = 9;
  localparam int DMX_DATA_W       = 8;
  localparam int DMX_MAX_CHANNELS = 512;

  typedef enum logic [1:0] {
    SLEW_IDLE = 2'd0,
    SLEW_SCAN = 2'd1,
    SLEW_DONE = 2'd2
  } slew_state_e;

  typedef struct packed {
    logic [DMX_ADDR_W-1:0] addr;
    logic [DMX_DATA_W-1:0] data;
  } rd_rsp_t;
endpackage

// File: rtl/dmx_slew_step.sv
// Next level of one channel: move current toward target by at most step, never past it.
module dmx_slew_step
  import dmx_pkg::*;
(
  input  logic [DMX_DATA_W-1:0] current,
  input  logic [DMX_DATA_W-1:0] target,
  input  logic [DMX_DATA_W-1:0] step,
  output logic [DMX_DATA_W-1:0] level_next
);
  logic [DMX_DATA_W:0] diff;

  always_comb begin
    diff       = '0;
    level_next = current;
    if (target > current) begin
      diff = {1'b0, target} - {1'b0, current};
      level_next = (diff > {1'b0, step}) ? current + step : target;
    end else if (current > target) begin
      diff = {1'b0, current} - {1'b0, target};
      level_next = (diff > {1'b0, step}) ? current - step : target;
    end
  end
endmodule

// File: rtl/dmx_channel_store.sv
// Per-channel level store feeding the DMX512 writer; optional per-packet slew (DMX_SLEW_EN).
module dmx_channel_store
  import dmx_pkg::*;
#(
  parameter int                  NUM_CHANNELS = 6,
  parameter logic [DMX_DATA_W-1:0] SLEW_STEP  = 8'd4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DMX_ADDR_W-1:0] wr_addr,
  input  logic [DMX_DATA_W-1:0] wr_data,
  input  logic                  frame_tick,
  input  logic                  request_pulse,
  input  logic [DMX_ADDR_W-1:0] request_addr,
  output logic [DMX_ADDR_W-1:0] addr,
  output logic [DMX_DATA_W-1:0] data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  overrun
);
  logic [NUM_CHANNELS-1:0][DMX_DATA_W-1:0] cur;
  logic [DMX_DATA_W-1:0]                   rd_val;
  rd_rsp_t                                 rsp;

  // Address decode by compare keeps out-of-range addresses reading as 0.
  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (request_addr == DMX_ADDR_W'(i + 1)) rd_val = cur[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rsp        <= '0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= request_pulse;
      if (request_pulse) rsp <= '{addr: request_addr, data: rd_val};
    end
  end

  assign addr = rsp.addr;
  assign data = rsp.data;

`ifdef DMX_SLEW_EN
  logic [NUM_CHANNELS-1:0][DMX_DATA_W-1:0] tgt;
  slew_state_e                             state, state_nxt;
  logic [DMX_ADDR_W-1:0]                   idx;
  logic                                    scan_en;
  logic [DMX_DATA_W-1:0]                   cur_sel, tgt_sel, step_out;

  always_ff @(posedge clk) begin
    if (reset) state <= SLEW_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SLEW_IDLE: if (frame_tick) state_nxt = SLEW_SCAN;
      SLEW_SCAN: if (idx == DMX_ADDR_W'(NUM_CHANNELS)) state_nxt = SLEW_DONE;
      SLEW_DONE: state_nxt = SLEW_IDLE;
      default:   state_nxt = SLEW_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != SLEW_IDLE);
    scan_en = (state == SLEW_SCAN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      if (state == SLEW_IDLE && frame_tick) idx <= DMX_ADDR_W'(1);
      else if (scan_en)                     idx <= idx + 1'b1;
      if (frame_tick && busy) overrun <= 1'b1;
    end
  end

  always_comb begin
    cur_sel = '0;
    tgt_sel = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      if (idx == DMX_ADDR_W'(i + 1)) begin
        cur_sel = cur[i];
        tgt_sel = tgt[i];
      end
  end

  dmx_slew_step u_step (
    .current    (cur_sel),
    .target     (tgt_sel),
    .step       (SLEW_STEP),
    .level_next (step_out)
  );

  // The scan step samples tgt before this edge, so a same-cycle write lands on the next pass.
  always_ff @(posedge clk) begin
    if (reset) begin
      tgt <= '0;
      cur <= '0;
    end else begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        if (wr_en && wr_addr == DMX_ADDR_W'(i + 1)) tgt[i] <= wr_data;
        if (scan_en && idx == DMX_ADDR_W'(i + 1))   cur[i] <= step_out;
      end
    end
  end
`else
  logic                  unused_tick;
  logic [DMX_DATA_W-1:0] unused_step;
  assign unused_tick = frame_tick;
  assign unused_step = SLEW_STEP;
  assign busy        = 1'b0;
  assign overrun     = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) cur <= '0;
    else
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (wr_en && wr_addr == DMX_ADDR_W'(i + 1)) cur[i] <= wr_data;
  end
`endif
endmodule

// File: tb/tb_dmx_channel_store.sv
// Directed bench for dmx_channel_store; covers both builds depending on DMX_SLEW_EN.
module tb_dmx_channel_store;
  localparam int N = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_tick;
  logic       request_pulse;
  logic [8:0] request_addr;
  logic [8:0] addr;
  logic [7:0] data;
  logic       data_valid;
  logic       busy;
  logic       overrun;

  int n_checks = 0;
  int n_fail   = 0;

  dmx_channel_store #(.NUM_CHANNELS(N), .SLEW_STEP(8'd4)) dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .frame_tick    (frame_tick),
    .request_pulse (request_pulse),
    .request_addr  (request_addr),
    .addr          (addr),
    .data          (data),
    .data_valid    (data_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [8:0] a, input logic [7:0] d);
    request_pulse = 1'b1; request_addr = a;
    step();
    request_pulse = 1'b0;
    check({tag, "_dv"},   32'(data_valid), 32'd1);
    check({tag, "_addr"}, 32'(addr),       32'(a));
    check({tag, "_data"}, 32'(data),       32'(d));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
  endtask

`ifdef DMX_SLEW_EN
  task automatic pass();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (N + 1) step();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    frame_tick = 1'b0; request_pulse = 1'b0; request_addr = '0;
    repeat (3) step();
    reset = 1'b0;

    check("rst_addr", 32'(addr),       32'd0);
    check("rst_data", 32'(data),       32'd0);
    check("rst_dv",   32'(data_valid), 32'd0);
    check("rst_busy", 32'(busy),       32'd0);
    check("rst_ovr",  32'(overrun),    32'd0);

    rd_chk("rd3", 9'd3, 8'd0);
    step();
    check("rd3_dv_drop", 32'(data_valid), 32'd0);
    check("rd3_hold",    32'(addr),       32'd3);

`ifdef DMX_SLEW_EN
    wr(9'd1, 8'd10);
    rd_chk("noslew_yet", 9'd1, 8'd0);
    pass(); rd_chk("slew1", 9'd1, 8'd4);
    pass(); rd_chk("slew2", 9'd1, 8'd8);
    pass(); rd_chk("slew3", 9'd1, 8'd10);
    pass(); rd_chk("slew4", 9'd1, 8'd10);
    wr(9'd1, 8'd0);
    pass(); rd_chk("slew_dn", 9'd1, 8'd6);

    // Second tick lands mid-pass; the pass must still end on schedule.
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("busy_start", 32'(busy), 32'd1);
    repeat (2) step();
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("ovr_set", 32'(overrun), 32'd1);
    repeat (3) step();
    check("busy_last", 32'(busy), 32'd1);
    step();
    check("busy_end", 32'(busy),    32'd0);
    check("ovr_hold", 32'(overrun), 32'd1);
    rd_chk("slew_dn2", 9'd1, 8'd2);
    pass();
    check("ovr_sticky", 32'(overrun), 32'd1);

    request_pulse = 1'b1; request_addr = 9'd1; step();
    check("b2b1_dv", 32'(data_valid), 32'd1); check("b2b1_addr", 32'(addr), 32'd1); check("b2b1_data", 32'(data), 32'd0);
    request_addr = 9'd2; step();
    check("b2b2_dv", 32'(data_valid), 32'd1); check("b2b2_addr", 32'(addr), 32'd2); check("b2b2_data", 32'(data), 32'd0);
    request_addr = 9'd3; step();
    check("b2b3_dv", 32'(data_valid), 32'd1); check("b2b3_addr", 32'(addr), 32'd3); check("b2b3_data", 32'(data), 32'd0);
    request_pulse = 1'b0; step();
    check("b2b_dv_drop", 32'(data_valid), 32'd0);

    do_reset();
    check("ovr_clr", 32'(overrun), 32'd0);
    check("busy_clr", 32'(busy), 32'd0);
    rd_chk("rst_ch1", 9'd1, 8'd0);

    wr(9'd4, 8'd20);
    wr(9'd7, 8'd55);
    pass(); rd_chk("ch4_a", 9'd4, 8'd4);
    rd_chk("ch1_alias", 9'd1, 8'd0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    repeat (3) step();
    wr_en = 1'b1; wr_addr = 9'd4; wr_data = 8'd0;
    request_pulse = 1'b1; request_addr = 9'd4;
    step();
    wr_en = 1'b0; request_pulse = 1'b0;
    check("ch4_pre", 32'(data), 32'd4);
    repeat (3) step();
    rd_chk("ch4_old_tgt", 9'd4, 8'd8);
    pass(); rd_chk("ch4_new_tgt", 9'd4, 8'd4);
`else
    wr(9'd2, 8'd200);
    rd_chk("wr2", 9'd2, 8'd200);
    wr(9'd0, 8'd55);
    wr(9'd7, 8'd55);
    rd_chk("rd0", 9'd0, 8'd0);
    rd_chk("rd7", 9'd7, 8'd0);
    rd_chk("rd1_alias", 9'd1, 8'd0);

    wr(9'd1, 8'd11);
    wr(9'd3, 8'd33);
    request_pulse = 1'b1; request_addr = 9'd1; step();
    check("b2b1_dv", 32'(data_valid), 32'd1); check("b2b1_addr", 32'(addr), 32'd1); check("b2b1_data", 32'(data), 32'd11);
    request_addr = 9'd2; step();
    check("b2b2_dv", 32'(data_valid), 32'd1); check("b2b2_addr", 32'(addr), 32'd2); check("b2b2_data", 32'(data), 32'd200);
    request_addr = 9'd3; step();
    check("b2b3_dv", 32'(data_valid), 32'd1); check("b2b3_addr", 32'(addr), 32'd3); check("b2b3_data", 32'(data), 32'd33);
    request_pulse = 1'b0; step();
    check("b2b_dv_drop", 32'(data_valid), 32'd0);

    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("tick_busy", 32'(busy), 32'd0);
    frame_tick = 1'b1; step(); frame_tick = 1'b0;
    check("tick_ovr", 32'(overrun), 32'd0);
    rd_chk("tick_nochg", 9'd2, 8'd200);

    wr_en = 1'b1; wr_addr = 9'd5; wr_data = 8'd77;
    request_pulse = 1'b1; request_addr = 9'd5;
    step();
    wr_en = 1'b0; request_pulse = 1'b0;
    check("wr_rd_same", 32'(data), 32'd0);
    rd_chk("wr_rd_after", 9'd5, 8'd77);
    rd_chk("rd6_top", 9'd6, 8'd0);

    do_reset();
    check("rst2_addr", 32'(addr), 32'd0);
    check("rst2_dv",   32'(data_valid), 32'd0);
    rd_chk("rst2_ch2", 9'd2, 8'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
